// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable generator: integer divide or phase-accumulator
// rates per channel, reprogrammed only at period boundaries, gated by DCM lock.
module clock_enable_gen #(
  parameter int CHANNELS = 2,
  parameter int DIV_W    = 8,
  parameter int ACC_W    = 16,
  parameter int DEF_DIV  = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      locked,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS*DIV_W-1:0] div,
  input  logic [CHANNELS*ACC_W-1:0] inc,
  input  logic [CHANNELS-1:0]       load,
  output logic [CHANNELS-1:0]       ce,
  output logic [CHANNELS-1:0]       lvl,
  output logic                      run
);

  logic sync1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      run   <= 1'b0;
    end else begin
      sync1 <= locked;
      run   <= sync1;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic             a_mode, p_mode, p_flag;
    logic [DIV_W-1:0] a_div, p_div, cnt;
    logic [ACC_W-1:0] a_inc, p_inc, acc;
    logic             ce_q, lvl_q;

    logic             n_mode, n_flag;
    logic [DIV_W-1:0] n_div, dd, dn, d_use, cnt_d;
    logic [ACC_W-1:0] n_inc, acc_d;
    logic [ACC_W:0]   sum;
    logic [DIV_W:0]   half;
    logic             wrap, bnd, apply, m_use, ce_d, lvl_d;

    // A load in the same cycle as a boundary wins over older pending values.
    always_comb begin
      n_flag = load[k] | p_flag;
      n_mode = load[k] ? mode[k] : p_mode;
      n_div  = load[k] ? div[k*DIV_W +: DIV_W] : p_div;
      n_inc  = load[k] ? inc[k*ACC_W +: ACC_W] : p_inc;
    end

    always_comb begin
      dd    = (a_div < DIV_W'(2)) ? DIV_W'(1) : a_div;
      dn    = (n_div < DIV_W'(2)) ? DIV_W'(1) : n_div;
      sum   = {1'b0, acc} + {1'b0, a_inc};
      wrap  = (cnt >= dd - 1'b1);
      bnd   = a_mode ? (sum[ACC_W] | (a_inc == '0)) : wrap;
      apply = run & n_flag & bnd;
      m_use = apply ? n_mode : a_mode;
      d_use = apply ? dn : dd;
      cnt_d = '0;
      acc_d = '0;
      ce_d  = 1'b0;
      lvl_d = 1'b0;
      half  = '0;
      if (run) begin
        if (a_mode) begin
          ce_d  = sum[ACC_W];
          acc_d = sum[ACC_W-1:0];
          cnt_d = cnt;
        end else begin
          ce_d  = wrap;
          acc_d = acc;
          cnt_d = wrap ? '0 : cnt + 1'b1;
        end
        // Switching modes starts the new mode from a clean phase.
        if (apply && (n_mode != a_mode)) begin
          cnt_d = '0;
          acc_d = '0;
        end
        half  = ({1'b0, d_use} + 1'b1) >> 1;
        lvl_d = m_use ? acc_d[ACC_W-1] : ({1'b0, cnt_d} < half);
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        a_mode <= 1'b0;
        a_div  <= DIV_W'(DEF_DIV);
        a_inc  <= '0;
        p_mode <= 1'b0;
        p_div  <= '0;
        p_inc  <= '0;
        p_flag <= 1'b0;
        cnt    <= '0;
        acc    <= '0;
        ce_q   <= 1'b0;
        lvl_q  <= 1'b0;
      end else begin
        cnt   <= cnt_d;
        acc   <= acc_d;
        ce_q  <= ce_d;
        lvl_q <= lvl_d;
        if (!run || apply) begin
          if (n_flag) begin
            a_mode <= n_mode;
            a_div  <= n_div;
            a_inc  <= n_inc;
          end
          p_flag <= 1'b0;
        end else if (load[k]) begin
          p_mode <= mode[k];
          p_div  <= div[k*DIV_W +: DIV_W];
          p_inc  <= inc[k*ACC_W +: ACC_W];
          p_flag <= 1'b1;
        end
      end
    end

    assign ce[k]  = ce_q;
    assign lvl[k] = lvl_q;
  end

endmodule
